// File: rtl/bnn_pkg.sv
// Shared types for the MNIST BNN pipeline.
// Layer blocks decode the state bus through state_t.
package bnn_pkg;

   localparam int IMG_BITS = 784;
   localparam int BEAT_W   = 8;

   typedef enum logic [2:0] {
      s_IDLE    = 3'b000,
      s_LOAD    = 3'b001,
      s_LAYER_1 = 3'b010,
      s_LAYER_2 = 3'b011,
      s_LAYER_3 = 3'b100,
      s_DONE    = 3'b101
   } state_t;

   // Sequencer-internal FSM; CLEAR has no bus encoding of its own.
   typedef enum logic [2:0] {
      F_IDLE,
      F_CLEAR,
      F_LOAD,
      F_L1,
      F_L2,
      F_L3,
      F_DONE
   } fsm_t;

endpackage

// File: rtl/bnn_watchdog.sv
// Per-layer watchdog: cleared on layer entry, counts while enabled,
// saturates at the last cycle and flags expiry there.
module bnn_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int W = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Inference sequencer: clears the layers, loads an image beat by beat,
// walks LAYER_1..3 under a watchdog and hands off the result.
module bnn_layer_sequencer
   import bnn_pkg::*;
#(
   parameter int LOAD_BEATS     = IMG_BITS / BEAT_W,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CLEAR_CYCLES   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          in_valid,
   input  logic [BEAT_W-1:0]             in_data,
   output logic                          in_ready,
   output logic                          load_we,
   output logic [$clog2(LOAD_BEATS)-1:0] load_addr,
   output logic [BEAT_W-1:0]             load_data,
   output logic [2:0]                    state,
   output logic                          layer_clr_n,
   input  logic                          l1_done,
   input  logic                          l2_done,
   input  logic                          l3_done,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic                          busy,
   output logic                          err_timeout
);

   localparam int AW = $clog2(LOAD_BEATS);
   localparam int CW = $clog2(CLEAR_CYCLES + 1);
   localparam logic [AW-1:0] BEAT_LAST = AW'(LOAD_BEATS - 1);
   localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_CYCLES - 1);

   fsm_t              fsm_q;
   state_t            state_q;
   logic [AW-1:0]     beat_cnt_q;
   logic [CW-1:0]     clr_cnt_q;
   logic              in_ready_q;
   logic              load_we_q;
   logic [AW-1:0]     load_addr_q;
   logic [BEAT_W-1:0] load_data_q;
   logic              clr_n_q;
   logic              result_valid_q;
   logic              busy_q;
   logic              err_q;

   logic   lyr_done;
   fsm_t   lyr_fsm_d;
   state_t lyr_st_d;
   logic   in_layer;
   logic   wd_clr;
   logic   wd_exp;

   always_comb begin
      lyr_done  = 1'b0;
      lyr_fsm_d = F_DONE;
      lyr_st_d  = s_DONE;
      unique case (fsm_q)
         F_L1: begin
            lyr_done  = l1_done;
            lyr_fsm_d = F_L2;
            lyr_st_d  = s_LAYER_2;
         end
         F_L2: begin
            lyr_done  = l2_done;
            lyr_fsm_d = F_L3;
            lyr_st_d  = s_LAYER_3;
         end
         F_L3:    lyr_done = l3_done;
         default: ;
      endcase
   end

   assign in_layer = fsm_q inside {F_L1, F_L2, F_L3};
   assign wd_clr   = !in_layer || lyr_done;

   bnn_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wd (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (wd_clr),
      .en_i     (in_layer),
      .expired_o(wd_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q          <= F_IDLE;
         state_q        <= s_IDLE;
         beat_cnt_q     <= '0;
         clr_cnt_q      <= '0;
         in_ready_q     <= 1'b0;
         load_we_q      <= 1'b0;
         load_addr_q    <= '0;
         load_data_q    <= '0;
         clr_n_q        <= 1'b0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         load_we_q <= 1'b0;
         unique case (fsm_q)
            F_IDLE: begin
               clr_n_q <= 1'b1;
               if (start) begin
                  err_q     <= 1'b0;
                  clr_n_q   <= 1'b0;
                  clr_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  fsm_q     <= F_CLEAR;
               end
            end
            F_CLEAR: begin
               if (clr_cnt_q == CLR_LAST) begin
                  clr_n_q    <= 1'b1;
                  in_ready_q <= 1'b1;
                  beat_cnt_q <= '0;
                  fsm_q      <= F_LOAD;
                  state_q    <= s_LOAD;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            F_LOAD: begin
               if (in_valid && in_ready_q) begin
                  load_we_q   <= 1'b1;
                  load_addr_q <= beat_cnt_q;
                  load_data_q <= in_data;
                  if (beat_cnt_q == BEAT_LAST) begin
                     in_ready_q <= 1'b0;
                     fsm_q      <= F_L1;
                     state_q    <= s_LAYER_1;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            F_L1, F_L2, F_L3: begin
               // A done on the expiry cycle still counts as success.
               if (lyr_done) begin
                  fsm_q          <= lyr_fsm_d;
                  state_q        <= lyr_st_d;
                  result_valid_q <= (fsm_q == F_L3);
               end else if (wd_exp) begin
                  err_q   <= 1'b1;
                  clr_n_q <= 1'b0;
                  busy_q  <= 1'b0;
                  fsm_q   <= F_IDLE;
                  state_q <= s_IDLE;
               end
            end
            F_DONE: begin
               if (result_ready) begin
                  result_valid_q <= 1'b0;
                  busy_q         <= 1'b0;
                  fsm_q          <= F_IDLE;
                  state_q        <= s_IDLE;
               end
            end
            default: begin
               fsm_q   <= F_IDLE;
               state_q <= s_IDLE;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign load_we      = load_we_q;
   assign load_addr    = load_addr_q;
   assign load_data    = load_data_q;
   assign state        = state_q;
   assign layer_clr_n  = clr_n_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;
   assign err_timeout  = err_q;

endmodule
